// File: rtl/native_pkg.sv
// -----------------------------------------------------------------------------
// native_pkg
// Shared types for the native request/update interface and its memory-side
// responder.
//   nat_op_t      request opcode carried on nat_request_op
//   resp_state_t  responder FSM state
// -----------------------------------------------------------------------------
package native_pkg;

    typedef enum logic [1:0] {
        NAT_NONE  = 2'b00,
        NAT_READ  = 2'b01,
        NAT_WRITE = 2'b10,
        NAT_ILL   = 2'b11
    } nat_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RESP
    } resp_state_t;

    // Width of the read-latency counter; holds values up to 15.
    localparam int LAT_CNT_W = 4;

    // Ops that touch the line store; everything else is flagged as illegal.
    function automatic logic is_mem_op(input nat_op_t op);
        return (op == NAT_READ) || (op == NAT_WRITE);
    endfunction

endpackage

// File: rtl/native_mem_responder_sram_sp.sv
// -----------------------------------------------------------------------------
// sram_sp
// Single-port behavioural line store.
//   clk    clock, rising edge
//   en     port enable; with we=1 writes, with we=0 reads
//   we     write enable
//   addr   line index
//   wdata  write line
//   rdata  registered read line, valid the cycle after an enabled read
// A write and a read never share a cycle (single port). The array and the
// read register carry no reset.
// -----------------------------------------------------------------------------
module sram_sp #(
    parameter int DW    = 256,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/native_mem_responder.sv
// -----------------------------------------------------------------------------
// native_mem_responder
// Memory end of the valid-ready native request/update interface. Line writes
// go straight into a single-port store; a line read is answered on the update
// channel a fixed number of cycles after it is accepted, and the answer is
// held until the initiator takes it. Only one read is ever outstanding.
//
// Ports
//   clk                clock, rising edge
//   rst                synchronous reset, active high
//   nat_request_valid  request present
//   nat_request_ready  responder can accept (IDLE and not in reset)
//   nat_request_op     00 none, 01 read, 10 write, 11 illegal
//   nat_request_addr   byte address; only the line-index bits are used
//   nat_request_data   write line
//   nat_update_valid   read line present
//   nat_update_ready   initiator takes the read line
//   nat_update_data    read line, held stable while nat_update_valid
//   err_illegal_op     sticky: an op 00 or 11 request was accepted
// -----------------------------------------------------------------------------
module native_mem_responder
    import native_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 256,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  nat_request_valid,
    output logic                  nat_request_ready,
    input  logic [1:0]            nat_request_op,
    input  logic [ADDR_WIDTH-1:0] nat_request_addr,
    input  logic [DATA_WIDTH-1:0] nat_request_data,
    output logic                  nat_update_valid,
    input  logic                  nat_update_ready,
    output logic [DATA_WIDTH-1:0] nat_update_data,
    output logic                  err_illegal_op
);

    localparam int OFF = $clog2(DATA_WIDTH / 8);
    localparam int IDX = $clog2(DEPTH);

    // The store read and the output register each cost one cycle, so the
    // response cannot be presented sooner than two cycles after accept.
    localparam int EFF_LAT = (READ_LATENCY < 2) ? 2 : READ_LATENCY;
    localparam logic [LAT_CNT_W-1:0] CNT_INIT = LAT_CNT_W'(EFF_LAT - 1);

    resp_state_t           state;
    logic [LAT_CNT_W-1:0]  lat_cnt;
    logic                  rd_pend;     // store output holds a fresh read line
    logic [DATA_WIDTH-1:0] data_q;
    logic                  err_q;

    nat_op_t               req_op;
    logic                  accept;
    logic                  ram_en;
    logic                  ram_we;
    logic [IDX-1:0]        ram_idx;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Offset bits and bits above the index are deliberately ignored so that
    // addresses wrap modulo DEPTH lines.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{nat_request_addr[ADDR_WIDTH-1:OFF+IDX],
                                nat_request_addr[OFF-1:0]};

    assign req_op            = nat_op_t'(nat_request_op);
    assign nat_request_ready = (state == IDLE) & ~rst;
    assign accept            = nat_request_valid & nat_request_ready;
    assign ram_en            = accept & is_mem_op(req_op);
    assign ram_we            = accept & (req_op == NAT_WRITE);
    assign ram_idx           = nat_request_addr[OFF +: IDX];

    sram_sp #(
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_store (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (nat_request_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
            rd_pend <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // The store output is only meaningful the cycle after a read;
            // capture it then and hold it until the next read.
            rd_pend <= ram_en & ~ram_we;
            if (rd_pend) begin
                data_q <= ram_rdata;
            end

            unique case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (req_op)
                            NAT_READ: begin
                                lat_cnt <= CNT_INIT;
                                state   <= RD_WAIT;
                            end
                            NAT_WRITE: begin
                                // Store write happens in u_store this edge.
                            end
                            default: begin
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end
                RD_WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (nat_update_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign nat_update_valid = (state == RESP);
    assign nat_update_data  = data_q;
    assign err_illegal_op   = err_q;

endmodule

// File: tb/tb_native_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_native_mem_responder
// Scoreboarded bench: request tasks update a line-level memory model and push
// the expected read line; an independent monitor checks every update
// handshake, response latency and data stability under backpressure.
// -----------------------------------------------------------------------------
module tb_native_mem_responder;

    localparam int AW    = 32;
    localparam int DW    = 256;
    localparam int DEPTH = 1024;
    localparam int LAT   = 4;
    localparam int LINE_BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          nat_request_valid;
    logic          nat_request_ready;
    logic [1:0]    nat_request_op;
    logic [AW-1:0] nat_request_addr;
    logic [DW-1:0] nat_request_data;
    logic          nat_update_valid;
    logic          nat_update_ready;
    logic [DW-1:0] nat_update_data;
    logic          err_illegal_op;

    native_mem_responder #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .nat_request_valid (nat_request_valid),
        .nat_request_ready (nat_request_ready),
        .nat_request_op    (nat_request_op),
        .nat_request_addr  (nat_request_addr),
        .nat_request_data  (nat_request_data),
        .nat_update_valid  (nat_update_valid),
        .nat_update_ready  (nat_update_ready),
        .nat_update_data   (nat_update_data),
        .err_illegal_op    (err_illegal_op)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic bp_force = 1'b0;

    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] exp_q [$];
    int            lat_q [$];
    int            written [$];

    always @(posedge clk) cyc++;

    // Update-channel ready: random, or forced low for backpressure tests.
    always @(posedge clk) begin
        #2;
        nat_update_ready = bp_force ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int lidx(input logic [AW-1:0] addr);
        return int'((addr / LINE_BYTES) % DEPTH);
    endfunction

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic          prev_valid = 1'b0;
    logic          prev_hs    = 1'b0;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (nat_update_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_update: got valid=1 data=%h, required no update", nat_update_data);
                end else begin
                    if (!prev_valid || prev_hs)
                        chk("read_latency", DW'(cyc - lat_q[0]), DW'(LAT));
                    else
                        chk("update_data_stable", nat_update_data, prev_data);
                    chk("req_ready_in_resp", DW'(nat_request_ready), DW'(0));
                    if (nat_update_ready) begin
                        chk("update_data", nat_update_data, exp_q[0]);
                        void'(exp_q.pop_front());
                        void'(lat_q.pop_front());
                    end
                end
            end
            prev_valid = nat_update_valid;
            prev_data  = nat_update_data;
            prev_hs    = nat_update_valid & nat_update_ready;
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] d, output int waited);
        nat_request_valid = 1'b1;
        nat_request_op    = op;
        nat_request_addr  = addr;
        nat_request_data  = d;
        waited = 0;
        @(negedge clk);
        while (!nat_request_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!nat_request_ready) begin
            checks++;
            failures++;
            $display("FAIL req_timeout: ready=0 after %0d cycles, required 1", waited);
            nat_request_valid = 1'b0;
            return;
        end
        // Accept happens at the coming edge.
        case (op)
            2'b10: begin
                model_mem[lidx(addr)] = d;
                written.push_back(lidx(addr));
            end
            2'b01: begin
                exp_q.push_back(model_mem[lidx(addr)]);
                lat_q.push_back(cyc);
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        nat_request_valid = 1'b0;
        nat_request_op    = 2'b00;
    endtask

    task automatic wait_resp();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: %0d responses pending, required 0", exp_q.size());
            exp_q.delete();
            lat_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        logic [DW-1:0] d0, d1, d2, dw;

        rst = 1'b1;
        nat_request_valid = 1'b0;
        nat_request_op    = 2'b00;
        nat_request_addr  = '0;
        nat_request_data  = '0;
        nat_update_ready  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", DW'(nat_request_ready), DW'(0));
        chk("rst_update_valid", DW'(nat_update_valid), DW'(0));
        chk("rst_update_data", nat_update_data, '0);
        chk("rst_err", DW'(err_illegal_op), DW'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", DW'(nat_request_ready), DW'(1));
        @(posedge clk);
        #1;

        // Write then read
        do_req(2'b10, 32'h0000_0040, {8{32'hA5A5_0001}}, w);
        do_req(2'b01, 32'h0000_0040, '0, w);
        wait_resp();

        // Back-to-back writes, then read each line back
        d0 = rand_line(); d1 = rand_line(); d2 = rand_line();
        do_req(2'b10, 32'h0000_0000, d0, w); chk("b2b_wait0", DW'(w), DW'(0));
        do_req(2'b10, 32'h0000_0020, d1, w); chk("b2b_wait1", DW'(w), DW'(0));
        do_req(2'b10, 32'h0000_0040, d2, w); chk("b2b_wait2", DW'(w), DW'(0));
        do_req(2'b01, 32'h0000_0000, '0, w); wait_resp();
        do_req(2'b01, 32'h0000_0020, '0, w); wait_resp();
        do_req(2'b01, 32'h0000_0040, '0, w); wait_resp();

        // Update backpressure for 10 cycles
        bp_force = 1'b1;
        do_req(2'b01, 32'h0000_0020, '0, w);
        for (int n = 0; n < 20 && !nat_update_valid; n++) @(negedge clk);
        for (int n = 0; n < 10; n++) begin
            chk("bp_valid_held", DW'(nat_update_valid), DW'(1));
            chk("bp_req_ready", DW'(nat_request_ready), DW'(0));
            @(negedge clk);
        end
        bp_force = 1'b0;
        wait_resp();

        // Wrap and offset: 0x5 and 0x8000 both map to line 0
        dw = rand_line();
        do_req(2'b10, 32'h0000_0005, dw, w);
        do_req(2'b01, 32'h0000_8000, '0, w);
        wait_resp();

        // Illegal ops: consumed, flag set, store untouched
        chk("err_before", DW'(err_illegal_op), DW'(0));
        do_req(2'b11, 32'h0000_0000, ~dw, w);
        @(negedge clk);
        chk("err_after_ill", DW'(err_illegal_op), DW'(1));
        @(posedge clk); #1;
        do_req(2'b00, 32'h0000_0000, ~dw, w);
        @(negedge clk);
        chk("err_sticky", DW'(err_illegal_op), DW'(1));
        @(posedge clk); #1;
        do_req(2'b01, 32'h0000_0000, '0, w);
        wait_resp();

        // Reset two cycles after a read accept
        do_req(2'b01, 32'h0000_0040, '0, w);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            chk("no_stale_update", DW'(nat_update_valid), DW'(0));
        end
        chk("mid_rst_ready", DW'(nat_request_ready), DW'(1));
        chk("mid_rst_err", DW'(err_illegal_op), DW'(0));
        @(posedge clk); #1;

        // Randomised traffic against the line model
        for (int i = 0; i < 80; i++) begin
            if (written.size() == 0 || $urandom_range(0, 1) == 0) begin
                do_req(2'b10, $urandom, rand_line(), w);
            end else begin
                int li;
                logic [AW-1:0] a;
                li = written[$urandom_range(0, written.size() - 1)];
                a  = AW'(li * LINE_BYTES + $urandom_range(0, LINE_BYTES - 1)
                         + $urandom_range(0, 7) * DEPTH * LINE_BYTES);
                do_req(2'b01, a, rand_line(), w);
                if ($urandom_range(0, 1) == 0) wait_resp();
            end
        end
        wait_resp();
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
